// File: rtl/cu_pkg.sv
// Shared encodings for the ARM multi-cycle control unit: states, condition
// codes, ALU opcodes, ALU B constant selects and access sizes.
package cu_pkg;

  typedef enum logic [3:0] {
    S_F0    = 4'd0,
    S_F1    = 4'd1,
    S_F2    = 4'd2,
    S_D0    = 4'd3,
    S_DP    = 4'd4,
    S_MA    = 4'd5,
    S_MR    = 4'd6,
    S_MR2   = 4'd7,
    S_MW0   = 4'd8,
    S_MW1   = 4'd9,
    S_BL0   = 4'd10,
    S_BR    = 4'd11,
    S_FAULT = 4'd12
  } state_t;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam logic [3:0] ALU_SUB = 4'h2;
  localparam logic [3:0] ALU_ADD = 4'h4;
  localparam logic [3:0] ALU_TST = 4'h8;
  localparam logic [3:0] ALU_CMN = 4'hB;
  localparam logic [3:0] ALU_MOV = 4'hD;

  localparam logic [1:0] CONST_DP   = 2'd0;
  localparam logic [1:0] CONST_ZERO = 2'd1;
  localparam logic [1:0] CONST_FOUR = 2'd2;

  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_BYTE = 2'b00;

  // TST/TEQ/CMP/CMN only update flags; they never write a register.
  function automatic logic is_test_op(input logic [3:0] op);
    return (op >= ALU_TST) && (op <= ALU_CMN);
  endfunction

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of an ARM condition field against the NZCV flags.
module cond_check
  import cu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       n,
  input  logic       z,
  input  logic       c,
  input  logic       v,
  output logic       pass
);

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the ARM datapath.
// Define CU_MFC_TIMEOUT_EN to fault when MFC does not arrive within MFC_TIMEOUT cycles.
module control_unit
  import cu_pkg::*;
`ifdef CU_MFC_TIMEOUT_EN
#(
  parameter int MFC_TIMEOUT = 15
)
`endif
(
  input  logic        Clk,
  input  logic        Clr,
  input  logic [31:0] IR,
  input  logic        N,
  input  logic        Z,
  input  logic        C,
  input  logic        V,
  input  logic        MFC,
  output logic        RegEn,
  output logic        IrEn,
  output logic        MarEn,
  output logic        MdrEn,
  output logic        MdrSel,
  output logic        RamEn,
  output logic        RW,
  output logic [1:0]  WordSel,
  output logic        Sel,
  output logic [1:0]  ConstSel,
  output logic [3:0]  AluOp,
  output logic        PcRead,
  output logic        PcWrite,
  output logic        LinkWrite,
  output logic        WbSel,
  output logic        FlagEn,
  output logic        Fault,
  output logic [3:0]  State
);

  state_t state, state_next;
  logic   cond_pass;
  logic   timeout_hit;
  logic   unused_ir;

  assign unused_ir = ^IR[19:0];

  cond_check u_cond_check (
    .cond (IR[31:28]),
    .n    (N),
    .z    (Z),
    .c    (C),
    .v    (V),
    .pass (cond_pass)
  );

  always_ff @(posedge Clk) begin
    if (!Clr) state <= S_F0;
    else      state <= state_next;
  end

`ifdef CU_MFC_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       in_wait;
  logic       enter_wait;

  assign in_wait    = (state == S_F1) || (state == S_MR) || (state == S_MW1);
  assign enter_wait = (state_next != state) &&
                      ((state_next == S_F1) || (state_next == S_MR) || (state_next == S_MW1));
  assign timeout_hit = in_wait && !MFC && (wait_cnt == 8'(MFC_TIMEOUT - 1));

  always_ff @(posedge Clk) begin
    if (!Clr)               wait_cnt <= '0;
    else if (enter_wait)    wait_cnt <= '0;
    else if (in_wait && !MFC) wait_cnt <= wait_cnt + 8'd1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      S_F0:  state_next = S_F1;
      S_F1:  if (MFC) state_next = S_F2;
      S_F2:  state_next = S_D0;
      S_D0: begin
        if (!cond_pass) state_next = S_F0;
        else begin
          case (IR[27:26])
            2'b00:   state_next = S_DP;
            2'b01:   state_next = S_MA;
            2'b10:   state_next = IR[24] ? S_BL0 : S_BR;
            default: state_next = S_FAULT;
          endcase
        end
      end
      S_DP:    state_next = S_F0;
      S_MA:    state_next = IR[20] ? S_MR : S_MW0;
      S_MR:    if (MFC) state_next = S_MR2;
      S_MR2:   state_next = S_F0;
      S_MW0:   state_next = S_MW1;
      S_MW1:   if (MFC) state_next = S_F0;
      S_BL0:   state_next = S_BR;
      S_BR:    state_next = S_F0;
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_FAULT;
    endcase
    if (timeout_hit) state_next = S_FAULT;
  end

  // Outputs are decoded from the state register; IrEn/MdrEn in wait states follow MFC.
  always_comb begin
    RegEn     = 1'b0;
    IrEn      = 1'b0;
    MarEn     = 1'b0;
    MdrEn     = 1'b0;
    MdrSel    = 1'b0;
    RamEn     = 1'b0;
    RW        = 1'b0;
    WordSel   = SIZE_BYTE;
    Sel       = 1'b0;
    ConstSel  = CONST_DP;
    AluOp     = 4'h0;
    PcRead    = 1'b0;
    PcWrite   = 1'b0;
    LinkWrite = 1'b0;
    WbSel     = 1'b0;
    FlagEn    = 1'b0;
    Fault     = 1'b0;
    case (state)
      S_F0: begin
        PcRead   = 1'b1;
        ConstSel = CONST_ZERO;
        AluOp    = ALU_ADD;
        MarEn    = 1'b1;
      end
      S_F1: begin
        RamEn   = 1'b1;
        RW      = 1'b1;
        WordSel = SIZE_WORD;
        IrEn    = MFC;
      end
      S_F2: begin
        PcRead   = 1'b1;
        PcWrite  = 1'b1;
        ConstSel = CONST_FOUR;
        AluOp    = ALU_ADD;
        RegEn    = 1'b1;
      end
      S_DP: begin
        AluOp  = IR[24:21];
        Sel    = IR[25];
        FlagEn = IR[20];
        RegEn  = !is_test_op(IR[24:21]);
      end
      S_MA: begin
        AluOp = IR[23] ? ALU_ADD : ALU_SUB;
        Sel   = 1'b1;
        MarEn = 1'b1;
      end
      S_MR: begin
        RamEn   = 1'b1;
        RW      = 1'b1;
        WordSel = IR[22] ? SIZE_BYTE : SIZE_WORD;
        MdrSel  = 1'b1;
        MdrEn   = MFC;
      end
      S_MR2: begin
        WbSel = 1'b1;
        RegEn = 1'b1;
      end
      S_MW0: begin
        AluOp  = ALU_MOV;
        MdrSel = 1'b0;
        MdrEn  = 1'b1;
      end
      S_MW1: begin
        RamEn   = 1'b1;
        RW      = 1'b0;
        WordSel = IR[22] ? SIZE_BYTE : SIZE_WORD;
      end
      S_BL0: begin
        PcRead    = 1'b1;
        LinkWrite = 1'b1;
        ConstSel  = CONST_ZERO;
        AluOp     = ALU_ADD;
        RegEn     = 1'b1;
      end
      S_BR: begin
        PcRead  = 1'b1;
        PcWrite = 1'b1;
        Sel     = 1'b0;
        AluOp   = ALU_ADD;
        RegEn   = 1'b1;
      end
      S_FAULT: Fault = 1'b1;
      default: Fault = 1'b1;
    endcase
  end

  assign State = state;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: fetch, data processing, conditions,
// load/store with MFC waits, branches, decode fault and reset abort.
module tb_control_unit;

  logic        Clk = 1'b0;
  logic        Clr = 1'b0;
  logic [31:0] IR  = 32'h0;
  logic        N = 1'b0, Z = 1'b0, C = 1'b0, V = 1'b0;
  logic        MFC = 1'b0;
  logic        RegEn, IrEn, MarEn, MdrEn, MdrSel, RamEn, RW;
  logic [1:0]  WordSel;
  logic        Sel;
  logic [1:0]  ConstSel;
  logic [3:0]  AluOp;
  logic        PcRead, PcWrite, LinkWrite, WbSel, FlagEn, Fault;
  logic [3:0]  State;

  int checks   = 0;
  int failures = 0;

  control_unit dut (
    .Clk(Clk), .Clr(Clr), .IR(IR), .N(N), .Z(Z), .C(C), .V(V), .MFC(MFC),
    .RegEn(RegEn), .IrEn(IrEn), .MarEn(MarEn), .MdrEn(MdrEn), .MdrSel(MdrSel),
    .RamEn(RamEn), .RW(RW), .WordSel(WordSel), .Sel(Sel), .ConstSel(ConstSel),
    .AluOp(AluOp), .PcRead(PcRead), .PcWrite(PcWrite), .LinkWrite(LinkWrite),
    .WbSel(WbSel), .FlagEn(FlagEn), .Fault(Fault), .State(State)
  );

  // clock / watchdog
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // From F0 with MFC=1: F0 -> F1 -> F2 -> D0.
  task automatic run_fetch();
    MFC = 1'b1;
    repeat (3) tick();
  endtask

  task automatic do_reset();
    Clr = 1'b0;
    repeat (2) tick();
    Clr = 1'b1;
  endtask

  task automatic test_reset();
    IR = 32'hE0810002; MFC = 1'b1;
    Clr = 1'b0;
    repeat (2) tick();
    checks++; if (State !== 4'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", State); end
    checks++; if (RamEn !== 1'b0 || Fault !== 1'b0) begin failures++; $display("FAIL reset_ram_fault got=%b%b exp=00", RamEn, Fault); end
    Clr = 1'b1;
  endtask

  task automatic test_fetch();
    checks++; if ({MarEn, PcRead, ConstSel, AluOp} !== {1'b1, 1'b1, 2'd1, 4'h4}) begin failures++; $display("FAIL f0_outputs got=%h exp=%h", {MarEn, PcRead, ConstSel, AluOp}, {1'b1, 1'b1, 2'd1, 4'h4}); end
    tick();
    checks++; if (State !== 4'd1) begin failures++; $display("FAIL f1_state got=%0d exp=1", State); end
    checks++; if ({RamEn, RW, WordSel, IrEn, MarEn} !== 6'b11_10_1_0) begin failures++; $display("FAIL f1_outputs got=%b exp=111010", {RamEn, RW, WordSel, IrEn, MarEn}); end
    tick();
    checks++; if (State !== 4'd2) begin failures++; $display("FAIL f2_state got=%0d exp=2", State); end
    checks++; if ({RegEn, PcWrite, PcRead, ConstSel, IrEn} !== 6'b111_10_0) begin failures++; $display("FAIL f2_outputs got=%b exp=111100", {RegEn, PcWrite, PcRead, ConstSel, IrEn}); end
    tick();
    checks++; if (State !== 4'd3) begin failures++; $display("FAIL d0_state got=%0d exp=3", State); end
  endtask

  task automatic test_dp();
    // ADD r0,r1,r2 : opcode 4, S=0; fetch already left us in D0
    tick();
    checks++; if (State !== 4'd4) begin failures++; $display("FAIL dp_add_state got=%0d exp=4", State); end
    checks++; if ({AluOp, RegEn, FlagEn, Sel} !== {4'h4, 1'b1, 1'b0, 1'b0}) begin failures++; $display("FAIL dp_add_outputs got=%b exp=0100100", {AluOp, RegEn, FlagEn, Sel}); end
    tick();
    checks++; if (State !== 4'd0) begin failures++; $display("FAIL dp_add_return got=%0d exp=0", State); end
    // CMP r1,r2 : opcode A, S=1, no write-back
    IR = 32'hE1510002;
    run_fetch();
    tick();
    checks++; if ({State, AluOp, RegEn, FlagEn} !== {4'd4, 4'hA, 1'b0, 1'b1}) begin failures++; $display("FAIL dp_cmp got=%b exp=0100101001", {State, AluOp, RegEn, FlagEn}); end
    // immediate operand selects the rotator
    IR = 32'hE2810002;
    tick();
    run_fetch();
    tick();
    checks++; if ({Sel, RegEn, AluOp} !== {1'b1, 1'b1, 4'h4}) begin failures++; $display("FAIL dp_imm got=%b exp=110100", {Sel, RegEn, AluOp}); end
    tick();
  endtask

  task automatic test_cond();
    // EQ with Z=0 fails: 4-cycle pass through F0..D0 and back to F0
    IR = 32'h00810002; Z = 1'b0;
    run_fetch();
    checks++; if (RegEn !== 1'b0) begin failures++; $display("FAIL cond_eq_d0_regen got=%b exp=0", RegEn); end
    tick();
    checks++; if (State !== 4'd0) begin failures++; $display("FAIL cond_eq_fail got=%0d exp=0", State); end
    Z = 1'b1;
    run_fetch();
    tick();
    checks++; if (State !== 4'd4) begin failures++; $display("FAIL cond_eq_pass got=%0d exp=4", State); end
    tick();
    IR = 32'hF0810002;
    run_fetch();
    tick();
    checks++; if (State !== 4'd0) begin failures++; $display("FAIL cond_nv got=%0d exp=0", State); end
    // GT: N!=V fails, N==V with Z=0 passes
    IR = 32'hC0810002; Z = 1'b0; N = 1'b1; V = 1'b0;
    run_fetch();
    tick();
    checks++; if (State !== 4'd0) begin failures++; $display("FAIL cond_gt_fail got=%0d exp=0", State); end
    V = 1'b1;
    run_fetch();
    tick();
    checks++; if (State !== 4'd4) begin failures++; $display("FAIL cond_gt_pass got=%0d exp=4", State); end
    tick();
    // HI: C=1,Z=0 passes; C=1,Z=1 fails
    IR = 32'h80810002; N = 1'b0; V = 1'b0; C = 1'b1; Z = 1'b1;
    run_fetch();
    tick();
    checks++; if (State !== 4'd0) begin failures++; $display("FAIL cond_hi_fail got=%0d exp=0", State); end
    Z = 1'b0;
    run_fetch();
    tick();
    checks++; if (State !== 4'd4) begin failures++; $display("FAIL cond_hi_pass got=%0d exp=4", State); end
    tick();
    C = 1'b0;
  endtask

  task automatic test_load_wait();
    // LDR r0,[r1] : pre-indexed, add offset, word, load
    IR = 32'hE5910000;
    run_fetch();
    MFC = 1'b0;
    tick();
    checks++; if ({State, AluOp, Sel, MarEn} !== {4'd5, 4'h4, 1'b1, 1'b1}) begin failures++; $display("FAIL ldr_ma got=%b exp=0101010011", {State, AluOp, Sel, MarEn}); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({State, RamEn, RW, WordSel, MdrSel, MdrEn} !== {4'd6, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0}) begin failures++; $display("FAIL ldr_mr_wait%0d got=%b exp=0110111010", i, {State, RamEn, RW, WordSel, MdrSel, MdrEn}); end
    end
    MFC = 1'b1;
    #1;
    checks++; if (MdrEn !== 1'b1) begin failures++; $display("FAIL ldr_mdren_on_mfc got=%b exp=1", MdrEn); end
    tick();
    checks++; if ({State, WbSel, RegEn, RamEn} !== {4'd7, 1'b1, 1'b1, 1'b0}) begin failures++; $display("FAIL ldr_mr2 got=%b exp=0111110", {State, WbSel, RegEn, RamEn}); end
    tick();
    checks++; if (State !== 4'd0) begin failures++; $display("FAIL ldr_return got=%0d exp=0", State); end
  endtask

  task automatic test_store();
    // STR word, add offset, completes when MFC arrives in MW1
    IR = 32'hE5810000;
    run_fetch();
    tick();
    checks++; if (State !== 4'd5) begin failures++; $display("FAIL str_ma got=%0d exp=5", State); end
    tick();
    checks++; if ({State, AluOp, MdrSel, MdrEn, RegEn} !== {4'd8, 4'hD, 1'b0, 1'b1, 1'b0}) begin failures++; $display("FAIL str_mw0 got=%b exp=10001101010", {State, AluOp, MdrSel, MdrEn, RegEn}); end
    tick();
    checks++; if ({State, RamEn, RW, WordSel, MdrEn} !== {4'd9, 1'b1, 1'b0, 2'b10, 1'b0}) begin failures++; $display("FAIL str_mw1 got=%b exp=100110100", {State, RamEn, RW, WordSel, MdrEn}); end
    tick();
    checks++; if (State !== 4'd0) begin failures++; $display("FAIL str_return got=%0d exp=0", State); end
  endtask

  task automatic test_reset_mid_store();
    // STRB with subtracted offset; MFC stalls in MW1, then reset aborts
    IR = 32'hE5410000;
    run_fetch();
    MFC = 1'b0;
    tick();
    checks++; if ({State, AluOp} !== {4'd5, 4'h2}) begin failures++; $display("FAIL strb_ma_sub got=%b exp=01010010", {State, AluOp}); end
    repeat (2) tick();
    tick();
    checks++; if ({State, RamEn, RW, WordSel} !== {4'd9, 1'b1, 1'b0, 2'b00}) begin failures++; $display("FAIL strb_mw1_hold got=%b exp=10011000", {State, RamEn, RW, WordSel}); end
    Clr = 1'b0;
    tick();
    checks++; if ({State, RamEn} !== {4'd0, 1'b0}) begin failures++; $display("FAIL strb_reset_abort got=%b exp=00000", {State, RamEn}); end
    Clr = 1'b1;
  endtask

  task automatic test_branch();
    IR = 32'hEB000004;
    run_fetch();
    tick();
    checks++; if ({State, LinkWrite, RegEn, PcRead, PcWrite, ConstSel} !== {4'd10, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1}) begin failures++; $display("FAIL bl0 got=%b exp=1010111001", {State, LinkWrite, RegEn, PcRead, PcWrite, ConstSel}); end
    tick();
    checks++; if ({State, PcWrite, RegEn, LinkWrite, Sel, ConstSel, AluOp} !== {4'd11, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'h4}) begin failures++; $display("FAIL br got=%b exp=1011110000100", {State, PcWrite, RegEn, LinkWrite, Sel, ConstSel, AluOp}); end
    tick();
    checks++; if (State !== 4'd0) begin failures++; $display("FAIL bl_return got=%0d exp=0", State); end
    // plain B skips the link step
    IR = 32'hEA000004;
    run_fetch();
    tick();
    checks++; if ({State, LinkWrite} !== {4'd11, 1'b0}) begin failures++; $display("FAIL b_direct got=%b exp=10110", {State, LinkWrite}); end
    tick();
  endtask

  task automatic test_fault();
    IR = 32'hEC000000;
    run_fetch();
    tick();
    checks++; if ({State, Fault, RegEn, RamEn, MarEn} !== {4'd12, 1'b1, 1'b0, 1'b0, 1'b0}) begin failures++; $display("FAIL fault_enter got=%b exp=11001000", {State, Fault, RegEn, RamEn, MarEn}); end
    MFC = 1'b0;
    repeat (3) tick();
    checks++; if ({State, Fault} !== {4'd12, 1'b1}) begin failures++; $display("FAIL fault_sticky got=%b exp=11001", {State, Fault}); end
    do_reset();
    checks++; if ({State, Fault} !== {4'd0, 1'b0}) begin failures++; $display("FAIL fault_clear got=%b exp=00000", {State, Fault}); end
  endtask

  task automatic test_mfc_wait();
    // MFC stuck low in F1
    MFC = 1'b0;
    tick();
    repeat (14) tick();
    checks++; if ({State, RamEn, IrEn} !== {4'd1, 1'b1, 1'b0}) begin failures++; $display("FAIL f1_wait_14 got=%b exp=000110", {State, RamEn, IrEn}); end
    tick();
`ifdef CU_MFC_TIMEOUT_EN
    checks++; if ({State, Fault, RamEn} !== {4'd12, 1'b1, 1'b0}) begin failures++; $display("FAIL f1_timeout got=%b exp=110010", {State, Fault, RamEn}); end
`else
    repeat (10) tick();
    checks++; if ({State, Fault, RamEn} !== {4'd1, 1'b0, 1'b1}) begin failures++; $display("FAIL f1_hold got=%b exp=000101", {State, Fault, RamEn}); end
`endif
    do_reset();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_dp();
    test_cond();
    test_load_wait();
    test_store();
    test_reset_mid_store();
    test_branch();
    test_fault();
    test_mfc_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
